axi_slave_mem: RTL and testbench

- AXI4 responder (slave end of the core's AXI bus) backed by an internal word-addressed SRAM.
- Serves core instruction/data AXI master traffic in simulation and FPGA bring-up; replaces external DDR for boot code and tests.
- Read and write channels are independent, each with one outstanding transaction; supports FIXED, INCR and WRAP bursts.

---
 rtl/axi_slave_mem.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
`timescale 1ns/1ps
// AXI4 slave backed by an internal word-addressed SRAM with FIXED/INCR/WRAP bursts.
// Read and write channels run independently, each with one outstanding transaction.
module axi_slave_mem #(
   parameter int unsigned           ID_WIDTH   = 2,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           MEM_WORDS  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ID_WIDTH-1:0]     aw_id,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]              aw_len,
   input  logic [2:0]              aw_size,
   input  logic [1:0]              aw_burst,
   input  logic                    aw_lock,
   input  logic [3:0]              aw_cache,
   input  logic [2:0]              aw_prot,
   input  logic [3:0]              aw_qos,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_last,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [ID_WIDTH-1:0]     b_id,
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [ID_WIDTH-1:0]     ar_id,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]              ar_len,
   input  logic [2:0]              ar_size,
   input  logic [1:0]              ar_burst,
   input  logic                    ar_lock,
   input  logic [3:0]              ar_cache,
   input  logic [2:0]              ar_prot,
   input  logic [3:0]              ar_qos,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [ID_WIDTH-1:0]     r_id,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_last,
   output logic                    r_valid,
   input  logic                    r_ready
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned BYTE_W = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS) << BYTE_W;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

   function automatic logic txn_bad(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
      logic len_ok;
      len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (32'(size) > BYTE_W) || (burst == 2'b11) || ((burst == 2'b10) && !len_ok);
   endfunction

   function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH:0] off;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      return (addr < BASE_ADDR) || (off >= MEM_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> BYTE_W);
   endfunction

   // WRAP keeps the upper address bits and wraps the low bits inside the burst window.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step, mask, res;
      step = ADDR_WIDTH'(1) << size;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   res = addr;
         2'b10:   res = (addr & ~mask) | ((addr + step) & mask);
         default: res = addr + step;
      endcase
      return res;
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   // Write channel state
   w_state_e              w_state_q, w_state_d;
   logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
   logic                  b_valid_q, b_valid_d;
   logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
   logic [1:0]            b_resp_q, b_resp_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [2:0]            wsize_q, wsize_d;
   logic [1:0]            wburst_q, wburst_d;
   logic                  werr_q, werr_d;
   logic                  w_beat, w_final, w_beat_err;

   assign w_beat     = w_ready_q && w_valid;
   assign w_final    = (wbeat_q == wlen_q);
   assign w_beat_err = txn_bad(wlen_q, wsize_q, wburst_q) || addr_bad(waddr_q);

   always_comb begin
      w_state_d  = w_state_q;
      aw_ready_d = aw_ready_q;
      w_ready_d  = w_ready_q;
      b_valid_d  = b_valid_q;
      b_id_d     = b_id_q;
      b_resp_d   = b_resp_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wbeat_d    = wbeat_q;
      wsize_d    = wsize_q;
      wburst_d   = wburst_q;
      werr_d     = werr_q;
      unique case (w_state_q)
         WIdle: begin
            aw_ready_d = 1'b1;
            if (aw_ready_q && aw_valid) begin
               aw_ready_d = 1'b0;
               w_ready_d  = 1'b1;
               b_id_d     = aw_id;
               waddr_d    = aw_addr;
               wlen_d     = aw_len;
               wsize_d    = aw_size;
               wburst_d   = aw_burst;
               wbeat_d    = '0;
               werr_d     = 1'b0;
               w_state_d  = WData;
            end
         end
         WData: begin
            if (w_beat) begin
               // A misplaced w_last only flags the response; the beat count is fixed by len.
               werr_d  = werr_q || w_beat_err || (w_last != w_final);
               waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
               wbeat_d = wbeat_q + 8'd1;
               if (w_final) begin
                  w_ready_d = 1'b0;
                  b_valid_d = 1'b1;
                  b_resp_d  = werr_d ? 2'b10 : 2'b00;
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            if (b_ready) begin
               b_valid_d  = 1'b0;
               aw_ready_d = 1'b1;
               w_state_d  = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= WIdle;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_id_q     <= '0;
         b_resp_q   <= '0;
         waddr_q    <= '0;
         wlen_q     <= '0;
         wbeat_q    <= '0;
         wsize_q    <= '0;
         wburst_q   <= '0;
         werr_q     <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         b_valid_q  <= b_valid_d;
         b_id_q     <= b_id_d;
         b_resp_q   <= b_resp_d;
         waddr_q    <= waddr_d;
         wlen_q     <= wlen_d;
         wbeat_q    <= wbeat_d;
         wsize_q    <= wsize_d;
         wburst_q   <= wburst_d;
         werr_q     <= werr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat && !w_beat_err) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (w_strb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

   // Read channel state
   r_state_e              r_state_q, r_state_d;
   logic                  ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   logic [1:0]            r_resp_q, r_resp_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [2:0]            rsize_q, rsize_d;
   logic [1:0]            rburst_q, rburst_d;
   logic                  r_beat_err;

   assign r_beat_err = txn_bad(rlen_q, rsize_q, rburst_q) || addr_bad(raddr_q);

   always_comb begin
      r_state_d  = r_state_q;
      ar_ready_d = ar_ready_q;
      r_valid_d  = r_valid_q;
      r_last_d   = r_last_q;
      r_id_d     = r_id_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      raddr_d    = raddr_q;
      rlen_d     = rlen_q;
      rbeat_d    = rbeat_q;
      rsize_d    = rsize_q;
      rburst_d   = rburst_q;
      unique case (r_state_q)
         RIdle: begin
            ar_ready_d = 1'b1;
            if (ar_ready_q && ar_valid) begin
               ar_ready_d = 1'b0;
               r_id_d     = ar_id;
               raddr_d    = ar_addr;
               rlen_d     = ar_len;
               rsize_d    = ar_size;
               rburst_d   = ar_burst;
               rbeat_d    = '0;
               r_state_d  = RFetch;
            end
         end
         RFetch: begin
            // Sampling the array here before this edge's write lands gives read-before-write.
            r_valid_d = 1'b1;
            r_last_d  = (rbeat_q == rlen_q);
            r_data_d  = r_beat_err ? '0 : mem[word_idx(raddr_q)];
            r_resp_d  = r_beat_err ? 2'b10 : 2'b00;
            r_state_d = RData;
         end
         RData: begin
            if (r_ready) begin
               r_valid_d = 1'b0;
               if (r_last_q) begin
                  ar_ready_d = 1'b1;
                  r_state_d  = RIdle;
               end else begin
                  raddr_d   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                  rbeat_d   = rbeat_q + 8'd1;
                  r_state_d = RFetch;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q  <= RIdle;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_last_q   <= 1'b0;
         r_id_q     <= '0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rbeat_q    <= '0;
         rsize_q    <= '0;
         rburst_q   <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_last_q   <= r_last_d;
         r_id_q     <= r_id_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         raddr_q    <= raddr_d;
         rlen_q     <= rlen_d;
         rbeat_q    <= rbeat_d;
         rsize_q    <= rsize_d;
         rburst_q   <= rburst_d;
      end
   end

   assign aw_ready = aw_ready_q;
   assign w_ready  = w_ready_q;
   assign b_valid  = b_valid_q;
   assign b_id     = b_id_q;
   assign b_resp   = b_resp_q;
   assign ar_ready = ar_ready_q;
   assign r_valid  = r_valid_q;
   assign r_last   = r_last_q;
   assign r_id     = r_id_q;
   assign r_data   = r_data_q;
   assign r_resp   = r_resp_q;

   logic unused_ok;
   assign unused_ok = ^{aw_lock, aw_cache, aw_prot, aw_qos, ar_lock, ar_cache, ar_prot, ar_qos};

endmodule

// File: tb/tb_axi_slave_mem.sv
`timescale 1ns/1ps
// Scoreboard bench for axi_slave_mem: a byte-level reference memory predicts every B and R
// response at issue time; monitors compare whatever the DUT presents.
module tb_axi_slave_mem;
   localparam int unsigned WORDS     = 4096;
   localparam longint      BASE      = 0;
   localparam longint      MEM_BYTES = longint'(WORDS) * 4;

   logic        clk, rst_n;
   logic [1:0]  aw_id, ar_id, b_id, r_id, aw_burst, ar_burst, b_resp, r_resp;
   logic [31:0] aw_addr, ar_addr, w_data, r_data;
   logic [7:0]  aw_len, ar_len;
   logic [2:0]  aw_size, ar_size;
   logic [3:0]  w_strb;
   logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
   logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

   axi_slave_mem #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS),
                   .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
      .aw_burst(aw_burst), .aw_lock(1'b0), .aw_cache(4'h0), .aw_prot(3'h0), .aw_qos(4'h0),
      .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
      .ar_burst(ar_burst), .ar_lock(1'b0), .ar_cache(4'h0), .ar_prot(3'h0), .ar_qos(4'h0),
      .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
      .r_ready(r_ready)
   );

   typedef struct packed {logic [1:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
   typedef struct packed {logic [1:0] id; logic [1:0] resp;} b_exp_t;

   r_exp_t      r_exp[$];
   b_exp_t      b_exp[$];
   logic [31:0] ref_mem [WORDS];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   int          checks = 0;
   int          errors = 0;
   bit          stall_en = 0;
   bit          gap_en = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference rules: address of beat i, whole-transaction error, out-of-range beat.
   function automatic longint beat_addr(longint a, int len, int size, int burst, int i);
      longint step, win, lo;
      step = longint'(1) << size;
      if (burst == 0) return a;
      if (burst == 2) begin
         win = longint'(len + 1) * step;
         lo  = (a / win) * win;
         return lo + ((a - lo + i * step) % win);
      end
      return a + i * step;
   endfunction

   function automatic bit txn_bad(int len, int size, int burst);
      return size > 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}));
   endfunction

   function automatic bit addr_bad(longint a);
      return a < BASE || a >= BASE + MEM_BYTES;
   endfunction

   // Monitors: every valid cycle is held against the head of the queue; pop on handshake.
   initial forever begin
      @(negedge clk);
      if (rst_n && r_valid) begin
         if (r_exp.size() == 0) check("r_unexpected", 64'(r_valid), 64'(0));
         else begin
            check("r_beat", 64'({r_id, r_data, r_resp, r_last}), 64'(r_exp[0]));
            if (r_ready) void'(r_exp.pop_front());
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && b_valid) begin
         if (b_exp.size() == 0) check("b_unexpected", 64'(b_valid), 64'(0));
         else begin
            check("b_resp", 64'({b_id, b_resp}), 64'(b_exp[0]));
            if (b_ready) void'(b_exp.pop_front());
         end
      end
   end

   initial begin
      r_ready = 1'b1;
      b_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         r_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         b_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_aw(input int id, input longint addr, input int len, input int size,
                          input int burst);
      int n = 0;
      bit hs;
      aw_id = 2'(id); aw_addr = 32'(addr); aw_len = 8'(len); aw_size = 3'(size);
      aw_burst = 2'(burst); aw_valid = 1'b1;
      do begin
         @(negedge clk); hs = aw_ready; @(posedge clk); #1; n++;
      end while (!hs && n < 200);
      aw_valid = 1'b0;
      if (!hs) check("aw_handshake", 64'(hs), 64'(1));
   endtask

   task automatic send_ar(input int id, input longint addr, input int len, input int size,
                          input int burst);
      int n = 0;
      bit hs;
      ar_id = 2'(id); ar_addr = 32'(addr); ar_len = 8'(len); ar_size = 3'(size);
      ar_burst = 2'(burst); ar_valid = 1'b1;
      do begin
         @(negedge clk); hs = ar_ready; @(posedge clk); #1; n++;
      end while (!hs && n < 200);
      ar_valid = 1'b0;
      if (!hs) check("ar_handshake", 64'(hs), 64'(1));
   endtask

   task automatic send_w(input int nbeats, input int last_at);
      int n;
      bit hs;
      for (int i = 0; i < nbeats; i++) begin
         if (gap_en) begin
            w_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         w_data = wd[i]; w_strb = ws[i]; w_last = (i == last_at); w_valid = 1'b1;
         n = 0;
         do begin
            @(negedge clk); hs = w_ready; @(posedge clk); #1; n++;
         end while (!hs && n < 200);
         if (!hs) begin
            check("w_handshake", 64'(hs), 64'(1));
            break;
         end
      end
      w_valid = 1'b0;
      w_last  = 1'b0;
   endtask

   task automatic do_write(input int id, input longint addr, input int len, input int size,
                           input int burst, input int last_at);
      bit txn, err, bad;
      longint a;
      int w;
      txn = txn_bad(len, size, burst);
      err = txn || (last_at != len);
      for (int i = 0; i <= len; i++) begin
         a   = beat_addr(addr, len, size, burst, i);
         bad = txn || addr_bad(a);
         err = err || bad;
         if (!bad) begin
            w = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
         end
      end
      b_exp.push_back('{id: 2'(id), resp: err ? 2'b10 : 2'b00});
      send_aw(id, addr, len, size, burst);
      send_w(len + 1, last_at);
   endtask

   task automatic do_read(input int id, input longint addr, input int len, input int size,
                          input int burst);
      bit txn, bad;
      longint a;
      r_exp_t e;
      txn = txn_bad(len, size, burst);
      for (int i = 0; i <= len; i++) begin
         a      = beat_addr(addr, len, size, burst, i);
         bad    = txn || addr_bad(a);
         e.id   = 2'(id);
         e.resp = bad ? 2'b10 : 2'b00;
         e.last = (i == len);
         if (bad) e.data = '0;
         else e.data = ref_mem[int'((a - BASE) >> 2)];
         r_exp.push_back(e);
      end
      send_ar(id, addr, len, size, burst);
   endtask

   task automatic drain();
      int n = 0;
      while ((b_exp.size() != 0 || r_exp.size() != 0) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (b_exp.size() != 0 || r_exp.size() != 0) begin
         check("drain_timeout", 64'(b_exp.size() + r_exp.size()), 64'(0));
         b_exp.delete();
         r_exp.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int burst, len, size, id;
      longint addr;
      rst_n = 1'b0;
      aw_valid = 0; w_valid = 0; ar_valid = 0; w_last = 0;
      aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
      ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
      w_data = 0; w_strb = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, b_resp,
                                   r_resp, b_id, r_id, r_data}), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ready", 64'({aw_ready, ar_ready, w_ready}), 64'(3'b110));

      // Single write/read with first-beat latency
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      do_write(1, 'h10, 0, 2, 1, 0);
      drain();
      do_read(2, 'h10, 0, 2, 1);
      check("r_latency_fetch", 64'(r_valid), 64'(0));
      @(posedge clk); #1;
      check("r_latency_data", 64'(r_valid), 64'(1));
      drain();

      // INCR burst, read back under random r_ready stalls
      for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
      do_write(0, 'h100, 3, 2, 1, 3);
      drain();
      stall_en = 1;
      do_read(3, 'h100, 3, 2, 1);
      drain();

      // WRAP and FIXED
      do_read(1, 'h108, 3, 2, 2);
      drain();
      wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
      do_write(2, 'h20, 0, 2, 1, 0);
      drain();
      do_read(0, 'h20, 3, 2, 0);
      drain();

      // Byte strobes
      wd[0] = 32'h11223344; ws[0] = 4'hF;
      do_write(1, 'h30, 0, 2, 1, 0);
      drain();
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
      do_write(1, 'h30, 0, 2, 1, 0);
      drain();
      do_read(1, 'h30, 0, 2, 1);
      drain();

      // Error cases
      do_read(3, 'h4000, 0, 2, 1);
      drain();
      wd[0] = 32'h12345678; ws[0] = 4'hF;
      do_write(0, 'h40, 0, 2, 1, 0);
      drain();
      wd[0] = 32'hFFFFFFFF;
      do_write(0, 'h40, 0, 3, 1, 0);
      drain();
      do_read(0, 'h40, 0, 2, 1);
      drain();
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      do_write(2, 'h50, 3, 2, 1, 1);
      drain();
      do_write(3, 'h3FF8, 3, 2, 1, 3);
      drain();
      do_read(3, 'h3FF8, 3, 2, 1);
      drain();
      do_write(1, 'h60, 2, 2, 2, 2);
      drain();
      do_read(2, 'h60, 0, 2, 3);
      drain();

      // Overlapping read and write bursts to disjoint words
      for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      fork
         do_write(1, 'h600, 7, 2, 1, 7);
         do_read(2, 'h100, 3, 2, 1);
      join
      drain();

      // Reset in the middle of a write burst
      stall_en = 0;
      send_aw(3, 'h700, 7, 2, 1);
      send_w(3, -1);
      w_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      check("reset_mid_burst", 64'({b_valid, w_ready, r_valid, aw_ready, ar_ready}), 64'(0));
      w_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("ready_after_reset", 64'({aw_ready, ar_ready, w_ready, b_valid}), 64'(4'b1100));
      wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
      do_write(2, 'h80, 0, 2, 1, 0);
      drain();
      do_read(2, 'h80, 0, 2, 1);
      drain();

      // Random traffic over a preloaded region
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
         do_write(k % 4, 'h1000 + longint'(k) * 64, 15, 2, 1, 15);
         drain();
      end
      stall_en = 1;
      gap_en = 1;
      for (int k = 0; k < 40; k++) begin
         burst = $urandom_range(0, 2);
         len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : int'($urandom_range(0, 15));
         size  = $urandom_range(0, 2);
         id    = $urandom_range(0, 3);
         addr  = 'h1000 + (longint'($urandom_range(0, 'h2F0)) & ~longint'(3));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(id, addr, len, size, burst, len);
         end else begin
            do_read(id, addr, len, size, burst);
         end
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
